// File: rtl/picomem_pkg.sv
// Shared PicoMem definitions used by the arbiter and its helper blocks.
//   PICOMEM_AW / PICOMEM_DW / PICOMEM_SW : address, data and strobe widths.
//   PICOMEM_TIMEOUT_RDATA                : read data returned when a watchdog
//                                          aborts a transaction.
//   arb_state_e                          : arbiter FSM state.
package picomem_pkg;

  localparam int PICOMEM_AW = 32;
  localparam int PICOMEM_DW = 32;
  localparam int PICOMEM_SW = 4;

  localparam logic [PICOMEM_DW-1:0] PICOMEM_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick_n.sv
// Combinational round-robin picker.
//   req      : request vector, one bit per requester.
//   last_idx : index served most recently; it gets the lowest priority.
//   next_idx : first requesting index searching upward from last_idx+1,
//              wrapping from N-1 to 0 (0 when nothing is requested).
//   found    : at least one request is present.
module rr_pick_n #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] next_idx,
  output logic             found
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Offsets 1..N visit every index once; offset N is last_idx itself,
    // so the previous owner is only picked when nobody else is asking.
    for (int off = 1; off <= N; off++) begin
      cand = int'(last_idx) + off;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found    = 1'b1;
        next_idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/picomem_arbiter_n_1.sv
// Round-robin arbiter sharing one PicoMem slave port between N_MASTERS
// PicoMem masters. A grant is held for one whole transaction and one idle
// arbitration cycle follows each transaction, so the slave always sees
// picos_valid drop between transactions.
//
// Handshake: a master raises picom_valid with stable addr/wdata/wstrb and
// holds it until its picom_ready bit pulses for one cycle; that cycle
// completes the transfer and carries the read data on picom_rdata. The slave
// side is the same contract on picos_valid/picos_ready. Dropping valid
// before ready abandons the request without a ready pulse.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset.
//   picom_valid/addr/wdata/wstrb : per-master request, master i in slice i.
//   picom_ready         : per-master completion pulse.
//   picom_rdata         : read data broadcast to all masters.
//   picos_*             : shared slave port.
//   grant_idx           : granted master (debug), holds its value in IDLE.
//   busy                : FSM state, high in GRANT.
//   timeout_err         : sticky watchdog flag (PICOMEM_ARB_TIMEOUT_EN only).
//
// Build option: define PICOMEM_ARB_TIMEOUT_EN to add a slave-ready watchdog
// that completes a stuck transaction after TIMEOUT_CYCLES grant cycles with
// TIMEOUT_RDATA.
module picomem_arbiter_n_1
  import picomem_pkg::*;
#(
  parameter int                    N_MASTERS      = 4,
  parameter int                    IDX_W          = $clog2(N_MASTERS),
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [PICOMEM_DW-1:0] TIMEOUT_RDATA  = PICOMEM_TIMEOUT_RDATA
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            picom_valid,
  input  logic [PICOMEM_AW*N_MASTERS-1:0] picom_addr,
  input  logic [PICOMEM_DW*N_MASTERS-1:0] picom_wdata,
  input  logic [PICOMEM_SW*N_MASTERS-1:0] picom_wstrb,
  output logic [N_MASTERS-1:0]            picom_ready,
  output logic [PICOMEM_DW-1:0]           picom_rdata,
  output logic                            picos_valid,
  output logic [PICOMEM_AW-1:0]           picos_addr,
  output logic [PICOMEM_DW-1:0]           picos_wdata,
  output logic [PICOMEM_SW-1:0]           picos_wstrb,
  input  logic                            picos_ready,
  input  logic [PICOMEM_DW-1:0]           picos_rdata,
  output logic [IDX_W-1:0]                grant_idx,
  output logic                            busy
`ifdef PICOMEM_ARB_TIMEOUT_EN
  ,
  output logic                            timeout_err
`endif
);

  arb_state_e       state;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             in_grant;
  logic             gnt_valid;
  logic             tmo_hit;
  logic             done;

  rr_pick_n #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (picom_valid),
    .last_idx (last_idx),
    .next_idx (pick_idx),
    .found    (pick_found)
  );

  assign in_grant  = (state == ARB_GRANT);
  assign gnt_valid = picom_valid[grant_idx];

`ifdef PICOMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // The counter holds the number of stalled grant cycles already elapsed,
  // so the cycle that would bring it to TIMEOUT_CYCLES is the abort cycle.
  assign tmo_hit = in_grant && !picos_ready &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!in_grant)        tmo_cnt <= '0;
      else if (!picos_ready) tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;

  // Watchdog parameters have no effect in this build.
  logic [PICOMEM_DW-1:0] unused_cfg;
  assign unused_cfg = TIMEOUT_RDATA ^ PICOMEM_DW'(TIMEOUT_CYCLES);
`endif

  // Normal completion, watchdog abort, or the owner walking away.
  assign done = in_grant && (picos_ready || tmo_hit || !gnt_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      last_idx  <= IDX_W'(N_MASTERS - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (done) begin
            last_idx <= grant_idx;
            state    <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign busy        = in_grant;
  assign picos_valid = in_grant && gnt_valid && !tmo_hit;
  assign picos_addr  = picom_addr[PICOMEM_AW*int'(grant_idx) +: PICOMEM_AW];
  assign picos_wdata = picom_wdata[PICOMEM_DW*int'(grant_idx) +: PICOMEM_DW];
  assign picos_wstrb = picom_wstrb[PICOMEM_SW*int'(grant_idx) +: PICOMEM_SW];
  assign picom_rdata = tmo_hit ? TIMEOUT_RDATA : picos_rdata;

  always_comb begin
    picom_ready = '0;
    if (in_grant) picom_ready[grant_idx] = picos_ready || tmo_hit;
  end

endmodule

// File: tb/tb_picomem_arbiter_n_1.sv
module tb_picomem_arbiter_n_1;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    picom_valid;
  logic [32*N-1:0] picom_addr;
  logic [32*N-1:0] picom_wdata;
  logic [4*N-1:0]  picom_wstrb;
  logic [N-1:0]    picom_ready;
  logic [31:0]     picom_rdata;
  logic            picos_valid;
  logic [31:0]     picos_addr;
  logic [31:0]     picos_wdata;
  logic [3:0]      picos_wstrb;
  logic            picos_ready;
  logic [31:0]     picos_rdata;
  logic [IW-1:0]   grant_idx;
  logic            busy;
`ifdef PICOMEM_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  logic [31:0] m_addr [N];
  logic [31:0] m_wdata[N];
  logic [3:0]  m_wstrb[N];

  always_comb begin
    picom_addr  = '0;
    picom_wdata = '0;
    picom_wstrb = '0;
    for (int i = 0; i < N; i++) begin
      picom_addr[32*i +: 32] = m_addr[i];
      picom_wdata[32*i +: 32] = m_wdata[i];
      picom_wstrb[4*i +: 4]   = m_wstrb[i];
    end
  end

  picomem_arbiter_n_1 #(
    .N_MASTERS      (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .picom_valid (picom_valid),
    .picom_addr  (picom_addr),
    .picom_wdata (picom_wdata),
    .picom_wstrb (picom_wstrb),
    .picom_ready (picom_ready),
    .picom_rdata (picom_rdata),
    .picos_valid (picos_valid),
    .picos_addr  (picos_addr),
    .picos_wdata (picos_wdata),
    .picos_wstrb (picos_wstrb),
    .picos_ready (picos_ready),
    .picos_rdata (picos_rdata),
    .grant_idx   (grant_idx),
    .busy        (busy)
`ifdef PICOMEM_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [IW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    picom_valid = '0;
    picos_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Run one full transaction from IDLE and check the grant it produces.
  task automatic run_txn(input logic [N-1:0] mask, input int lat, input int exp_idx,
                         input logic [31:0] rdata);
    picom_valid = mask;
    picos_ready = 1'b0;
    #1;
    check("tbl_idle_valid", picos_valid, 0);
    step();
    check("tbl_busy", busy, 1);
    check("tbl_grant", grant_idx, exp_idx);
    check("tbl_valid", picos_valid, 1);
    check("tbl_addr", picos_addr, m_addr[exp_idx]);
    check("tbl_wstrb", picos_wstrb, m_wstrb[exp_idx]);
    check("tbl_no_ready", picom_ready, 0);
    repeat (lat) step();
    picos_ready = 1'b1;
    picos_rdata = rdata;
    #1;
    check("tbl_ready", picom_ready, 64'(1) << exp_idx);
    check("tbl_rdata", picom_rdata, rdata);
    step();
    picos_ready = 1'b0;
    picom_valid = '0;
    #1;
    check("tbl_gap_valid", picos_valid, 0);
    check("tbl_gap_busy", busy, 0);
    check("tbl_grant_hold", grant_idx, exp_idx);
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           lat;
    int           exp_idx;
    logic [31:0]  rdata;
  } vec_t;

  vec_t vecs[7];

  // ---------------- reference model state ----------------
  int          owner;
  int          last;
  int          stall;
  int          act_idx;
  logic [N-1:0] prev_rdy;
  logic [N-1:0] exp_rdy;
  int          rr_exp[5];

  initial begin
    rst         = 1'b1;
    picom_valid = '0;
    picos_ready = 1'b0;
    picos_rdata = '0;
    m_addr  = '{32'h8000_0000, 32'h8000_1004, 32'h8100_0010, 32'h8700_0FFC};
    m_wdata = '{32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    m_wstrb = '{4'b0000, 4'b1111, 4'b0000, 4'b1000};
    #2;
    // reset state
    check("rst_valid", picos_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_ready", picom_ready, 0);
`ifdef PICOMEM_ARB_TIMEOUT_EN
    check("rst_tmo_err", timeout_err, 0);
`endif
    step();
    rst = 1'b0;

    // ---------------- table-driven arbitration vectors ----------------
    // Grants derived by hand from round-robin order, starting with
    // last_idx = 3 after reset.
    vecs[0] = '{4'b0100, 2, 2, 32'h1234_5678};
    vecs[1] = '{4'b1111, 0, 3, 32'h0BAD_F00D};
    vecs[2] = '{4'b0011, 1, 0, 32'hCAFE_0001};
    vecs[3] = '{4'b0011, 0, 1, 32'hCAFE_0002};
    vecs[4] = '{4'b1001, 3, 3, 32'h5555_AAAA};
    vecs[5] = '{4'b0110, 0, 1, 32'h0000_0001};
    vecs[6] = '{4'b0001, 1, 0, 32'hFFFF_FFFF};
    for (int v = 0; v < 7; v++) run_txn(vecs[v].mask, vecs[v].lat, vecs[v].exp_idx, vecs[v].rdata);

    // ---------------- all masters requesting, slave ready at once ----------------
    do_reset();
    rr_exp = '{0, 1, 2, 3, 0};
    picom_valid = '1;
    picos_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_grant", grant_idx, rr_exp[k]);
      check("rr_valid", picos_valid, 1);
      check("rr_ready", picom_ready, 64'(1) << rr_exp[k]);
      step();
      check("rr_gap_valid", picos_valid, 0);
      check("rr_gap_ready", picom_ready, 0);
    end
    picom_valid = '0;
    picos_ready = 1'b0;
    step();

    // ---------------- request arriving on the completion cycle ----------------
    m_wstrb[1] = 4'b0011;
    m_wdata[1] = 32'hAABB_CCDD;
    m_addr[0]  = 32'h8200_0040;
    m_wstrb[0] = 4'b0101;
    m_wdata[0] = 32'h0102_0304;
    picom_valid = 4'b0010;
    step();
    check("late_grant1", grant_idx, 1);
    check("late_wstrb1", picos_wstrb, 4'b0011);
    check("late_wdata1", picos_wdata, 32'hAABB_CCDD);
    step();
    picos_ready = 1'b1;
    picom_valid = 4'b0011;
    #1;
    check("late_ready1", picom_ready, 4'b0010);
    step();
    picom_valid = 4'b0001;
    picos_ready = 1'b0;
    #1;
    check("late_gap_valid", picos_valid, 0);
    check("late_gap_busy", busy, 0);
    step();
    check("late_grant0", grant_idx, 0);
    check("late_valid0", picos_valid, 1);
    check("late_addr0", picos_addr, 32'h8200_0040);
    check("late_wstrb0", picos_wstrb, 4'b0101);
    check("late_wdata0", picos_wdata, 32'h0102_0304);
    picos_ready = 1'b1;
    #1;
    check("late_ready0", picom_ready, 4'b0001);
    step();
    picom_valid = '0;
    picos_ready = 1'b0;

    // ---------------- reset in the middle of a grant ----------------
    picom_valid = 4'b1000;
    step();
    check("mid_grant3", grant_idx, 3);
    check("mid_valid3", picos_valid, 1);
    picos_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", picos_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", picom_ready, 0);
    check("mid_rst_grant", grant_idx, 0);
    picom_valid = 4'b1001;
    step();
    rst = 1'b0;
    picos_ready = 1'b0;
    step();
    check("post_rst_grant0", grant_idx, 0);
    check("post_rst_addr0", picos_addr, 32'h8200_0040);
    picos_ready = 1'b1;
    #1;
    check("post_rst_ready0", picom_ready, 4'b0001);
    step();
    picom_valid = 4'b1000;
    picos_ready = 1'b0;
    step();
    check("post_rst_grant3", grant_idx, 3);
    picos_ready = 1'b1;
    #1;
    check("post_rst_ready3", picom_ready, 4'b1000);
    step();
    picom_valid = '0;
    picos_ready = 1'b0;

    // ---------------- granted master abandons its request ----------------
    picom_valid = 4'b0100;
    step();
    check("drop_grant2", grant_idx, 2);
    picom_valid = 4'b1000;
    #1;
    check("drop_valid", picos_valid, 0);
    check("drop_ready", picom_ready, 0);
    check("drop_busy", busy, 1);
    step();
    check("drop_idle_busy", busy, 0);
    check("drop_idle_ready", picom_ready, 0);
    step();
    check("drop_grant3", grant_idx, 3);
    check("drop_valid3", picos_valid, 1);
    check("drop_addr3", picos_addr, m_addr[3]);
    picos_ready = 1'b1;
    step();
    picom_valid = '0;
    picos_ready = 1'b0;

`ifdef PICOMEM_ARB_TIMEOUT_EN
    // ---------------- watchdog abort ----------------
    do_reset();
    picom_valid = 4'b0001;
    picos_rdata = 32'h1111_2222;
    step();
    for (int c = 1; c <= TMO; c++) begin
      if (c < TMO) begin
        check("tmo_wait_ready", picom_ready, 0);
        check("tmo_wait_valid", picos_valid, 1);
      end else begin
        check("tmo_ready", picom_ready, 4'b0001);
        check("tmo_valid", picos_valid, 0);
        check("tmo_rdata", picom_rdata, 32'hDEAD_BEEF);
      end
      step();
    end
    picom_valid = '0;
    #1;
    check("tmo_idle_busy", busy, 0);
    check("tmo_err_set", timeout_err, 1);
    step();
    step();
    check("tmo_err_sticky", timeout_err, 1);
`endif

    // ---------------- randomized traffic vs. transaction-level model ----------------
    do_reset();
    owner    = -1;
    last     = N - 1;
    stall    = 0;
    prev_rdy = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (prev_rdy[i]) begin
          picom_valid[i] = 1'b0;
        end else if (!picom_valid[i] && $urandom_range(0, 2) == 0) begin
          picom_valid[i] = 1'b1;
          m_addr[i]      = $urandom;
          m_wdata[i]     = $urandom;
          m_wstrb[i]     = 4'($urandom_range(0, 15));
        end
      end
      picos_ready = (stall >= 6) || ($urandom_range(0, 2) == 0);
      stall       = picos_ready ? 0 : stall + 1;
      picos_rdata = $urandom;
      #1;

      exp_rdy = '0;
      if (owner >= 0 && picos_ready) exp_rdy[owner] = 1'b1;
      check("rnd_busy", busy, (owner >= 0));
      check("rnd_valid", picos_valid, (owner >= 0) && picom_valid[owner]);
      check("rnd_ready", picom_ready, exp_rdy);
      check("rnd_rdata", picom_rdata, picos_rdata);
      if (owner >= 0) begin
        check("rnd_grant", grant_idx, owner);
        check("rnd_addr", picos_addr, m_addr[owner]);
        check("rnd_wdata", picos_wdata, m_wdata[owner]);
        check("rnd_wstrb", picos_wstrb, m_wstrb[owner]);
      end

      if (exp_rdy != 0) exp_q.push_back(IW'(owner));
      if (picom_ready != 0) begin
        act_idx = -1;
        for (int i = 0; i < N; i++) if (picom_ready[i] && act_idx < 0) act_idx = i;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected_done: got master %0d expected none", act_idx);
        end else begin
          check("sb_done_idx", act_idx, exp_q.pop_front());
        end
      end

      // Model transition: idle picks the next requester after the last one
      // served; a grant ends on slave ready or when its owner lets go.
      if (owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (owner < 0 && picom_valid[(last + k) % N]) owner = (last + k) % N;
        end
      end else if (picos_ready || !picom_valid[owner]) begin
        last  = owner;
        owner = -1;
      end
      prev_rdy = exp_rdy;
      step();
    end
    check("sb_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
